// File: rtl/mmcm_drp_ctrl.sv
// DRP master that read-modify-writes MMCME4_ADV registers while holding the MMCM in reset.
// Optional LOCK_TIMEOUT_EN bounds the wait for mmcm_locked after release.
module mmcm_drp_ctrl #(
  parameter int unsigned RST_HOLD     = 4,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        clk_in0,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [6:0]  cfg_addr,
  input  logic [15:0] cfg_mask,
  input  logic [15:0] cfg_data,
  input  logic        cfg_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked
);

  // One shared cycle counter, sized for the largest of the three waits.
  localparam int unsigned MaxA   = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
  localparam int unsigned MaxCnt = (MaxA > LOCK_TIMEOUT) ? MaxA : LOCK_TIMEOUT;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] HoldLast = CntW'((RST_HOLD > 0) ? RST_HOLD - 1 : 0);
  localparam logic [CntW-1:0] DrdyLast = CntW'((DRDY_TIMEOUT > 0) ? DRDY_TIMEOUT - 1 : 0);
`ifdef LOCK_TIMEOUT_EN
  localparam logic [CntW-1:0] LockLast = CntW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
`endif

  typedef enum logic [3:0] {
    StIdle, StHold, StRdReq, StRdWait, StWrReq, StWrWait, StNext, StRelease, StWaitLock
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic [6:0]      addr_q, daddr_q;
  logic [15:0]     mask_q, data_q, rdata_q, di_q;
  logic            last_q;
  logic            ready_int, rst_int, den_int, dwe_int;
  logic            accept;
  logic [15:0]     wdata;

  assign wdata  = (rdata_q & mask_q) | (data_q & ~mask_q);
  assign accept = cfg_valid & ready_int;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    ready_int = 1'b0;
    rst_int   = 1'b0;
    den_int   = 1'b0;
    dwe_int   = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready_int = 1'b1;
        if (cfg_valid) begin
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        rst_int = 1'b1;
        if (cnt_q >= HoldLast) begin
          if (!mmcm_locked) state_d = StRdReq;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRdReq: begin
        rst_int = 1'b1;
        den_int = 1'b1;
        cnt_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        rst_int = 1'b1;
        if (drp_drdy) begin
          state_d = StWrReq;
        end else if (cnt_q >= DrdyLast) begin
          err_d   = 1'b1;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrReq: begin
        rst_int = 1'b1;
        den_int = 1'b1;
        dwe_int = 1'b1;
        cnt_d   = '0;
        state_d = StWrWait;
      end
      StWrWait: begin
        rst_int = 1'b1;
        if (drp_drdy) begin
          state_d = last_q ? StRelease : StNext;
        end else if (cnt_q >= DrdyLast) begin
          err_d   = 1'b1;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StNext: begin
        rst_int   = 1'b1;
        ready_int = 1'b1;
        if (cfg_valid) state_d = StRdReq;
      end
      StRelease: begin
`ifdef LOCK_TIMEOUT_EN
        // The release cycle itself counts toward the lock timeout.
        cnt_d = CntW'(1);
`endif
        state_d = StWaitLock;
      end
      StWaitLock: begin
        if (mmcm_locked) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
`ifdef LOCK_TIMEOUT_EN
        else if (cnt_q >= LockLast) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in0) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      rdata_q <= '0;
      daddr_q <= '0;
      di_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      if (accept) begin
        addr_q <= cfg_addr;
        mask_q <= cfg_mask;
        data_q <= cfg_data;
        last_q <= cfg_last;
      end
      if (state_q == StRdWait && drp_drdy) rdata_q <= drp_do;
      if (den_int) daddr_q <= addr_q;
      if (state_q == StWrReq) di_q <= wdata;
    end
  end

  // Reset forces every output low combinationally so an abort is seen at once.
  assign cfg_ready = ready_int & ~reset;
  assign busy      = (state_q != StIdle) & ~reset;
  assign done      = done_q & ~reset;
  assign err       = err_q & ~reset;
  assign drp_den   = den_int & ~reset;
  assign drp_dwe   = dwe_int & ~reset;
  assign mmcm_rst  = rst_int & ~reset;
  assign drp_daddr = reset ? 7'd0 : (den_int ? addr_q : daddr_q);
  assign drp_di    = reset ? 16'd0 : ((state_q == StWrReq) ? wdata : di_q);

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Scoreboard bench for mmcm_drp_ctrl: a behavioural DRP slave and MMCM lock model drive the DUT,
// expected DRP traffic and completion status are queued by the stimulus and checked by a monitor.
module tb_mmcm_drp_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid, cfg_ready, cfg_last;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_mask, cfg_data;
  logic        busy, done, err;
  logic        drp_den, drp_dwe, drp_drdy;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di, drp_do;
  logic        mmcm_rst, mmcm_locked;

  always #5 clk = ~clk;

  mmcm_drp_ctrl #(
    .RST_HOLD     (4),
    .DRDY_TIMEOUT (64),
    .LOCK_TIMEOUT (100)
  ) dut (
    .clk_in0     (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_mask    (cfg_mask),
    .cfg_data    (cfg_data),
    .cfg_last    (cfg_last),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .drp_den     (drp_den),
    .drp_dwe     (drp_dwe),
    .drp_daddr   (drp_daddr),
    .drp_di      (drp_di),
    .drp_do      (drp_do),
    .drp_drdy    (drp_drdy),
    .mmcm_rst    (mmcm_rst),
    .mmcm_locked (mmcm_locked)
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference register file and expected-response queues.
  logic [15:0] ref_mem [128];
  logic [15:0] mem     [128];
  logic [6:0]  exp_rd   [$];
  logic [22:0] exp_wr   [$];
  bit          exp_done [$];

  task automatic expect_reg(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                            input bit with_write);
    logic [15:0] nv;
    exp_rd.push_back(a);
    if (with_write) begin
      nv = (ref_mem[a] & m) | (d & ~m);
      ref_mem[a] = nv;
      exp_wr.push_back({a, nv});
    end
  endtask

  // DRP slave: answers each den with drdy lat+1 cycles later, optionally dropping one read.
  int unsigned lat = 0;
  int          drop_rd = -1;
  int          rd_idx = 0;
  initial begin : drp_slave
    logic [6:0] s_a;
    logic       s_w;
    bit         s_drop;
    drp_drdy = 1'b0;
    drp_do   = 16'h0;
    forever begin
      @(negedge clk);
      if (!reset && drp_den) begin
        s_a    = drp_daddr;
        s_w    = drp_dwe;
        s_drop = 1'b0;
        if (s_w) begin
          mem[s_a] = drp_di;
        end else begin
          s_drop = (rd_idx == drop_rd);
          rd_idx++;
        end
        if (!s_drop) begin
          repeat (lat) @(posedge clk);
          @(posedge clk);
          #1;
          drp_drdy = 1'b1;
          drp_do   = s_w ? 16'h0 : mem[s_a];
          @(posedge clk);
          #1;
          drp_drdy = 1'b0;
        end
      end
    end
  end

  // MMCM lock model: drops lock while in reset, locks when the test allows it.
  bit lock_stuck = 1'b0;
  bit lock_go    = 1'b0;
  initial begin : lock_model
    mmcm_locked = 1'b0;
    forever begin
      @(negedge clk);
      if (lock_stuck)    mmcm_locked = 1'b1;
      else if (mmcm_rst) mmcm_locked = 1'b0;
      else if (lock_go)  mmcm_locked = 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents DRP traffic or done.
  int unsigned rd_cycs [$];
  int unsigned wr_cyc, rel_cyc, done_cyc, err_rise_cyc;
  int          wr_cnt = 0, rst_falls = 0, done_cnt = 0;
  logic        prev_rst = 1'b0, prev_err = 1'b0;
  initial begin : monitor
    logic [22:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (drp_den && !drp_dwe) begin
          rd_cycs.push_back(cyc);
          if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: got read at 0x%0h, expected none", drp_daddr);
          end else check("rd_addr", 32'(drp_daddr), 32'(exp_rd.pop_front()));
        end
        if (drp_den && drp_dwe) begin
          wr_cnt++;
          wr_cyc = cyc;
          if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_unexpected: got write 0x%0h at 0x%0h, expected none", drp_di,
                     drp_daddr);
          end else begin
            e = exp_wr.pop_front();
            check("wr_addr", 32'(drp_daddr), 32'(e[22:16]));
            check("wr_data", 32'(drp_di), 32'(e[15:0]));
          end
        end
        if (prev_rst && !mmcm_rst) begin
          rst_falls++;
          rel_cyc = cyc;
        end
        if (!prev_err && err) err_rise_cyc = cyc;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          if (exp_done.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: got done, expected none");
          end else check("done_err", 32'(err), 32'(exp_done.pop_front()));
        end
      end
      prev_rst = mmcm_rst & ~reset;
      prev_err = err;
    end
  end

  int unsigned acc_cyc;
  logic        acc_busy;

  task automatic send_req(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                          input logic l);
    int n = 0;
    tick();
    cfg_addr  = a;
    cfg_mask  = m;
    cfg_data  = d;
    cfg_last  = l;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 400) begin
      tick();
      n++;
    end
    if (!cfg_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no cfg_ready in 400 cycles, expected accept");
    end
    acc_cyc  = cyc;
    acc_busy = busy;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic start_test();
    wr_cnt    = 0;
    rst_falls = 0;
    done_cnt  = 0;
    rd_cycs.delete();
  endtask

  task automatic wait_release(input string nm);
    int n = 0;
    while (rst_falls == 0 && n < 400) begin
      tick();
      n++;
    end
    if (rst_falls == 0) begin
      checks++; errors++;
      $display("FAIL %s_release: got no mmcm_rst release in 400 cycles, expected one", nm);
    end
  endtask

  // Lets the MMCM lock after release and checks done follows lock by one cycle.
  task automatic finish_batch(input string nm);
    int unsigned lc;
    int n = 0;
    wait_release(nm);
    tick();
    @(posedge clk);
    #1;
    lock_go = 1'b1;
    lc = cyc;
    while (done_cnt == 0 && n < 100) begin
      tick();
      n++;
    end
    if (done_cnt == 0) begin
      checks++; errors++;
      $display("FAIL %s_done: got no done in 100 cycles, expected done", nm);
    end else check({nm, "_done_lat"}, done_cyc, lc + 1);
    lock_go = 1'b0;
  endtask

  logic [6:0]  ra [3];
  logic [15:0] rm [3], rdv [3];

  initial begin : main
    int          n;
    int unsigned acc2, fall_cyc;
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_mask  = '0;
    cfg_data  = '0;
    cfg_last  = 1'b0;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 16'($urandom);
      mem[i]     = ref_mem[i];
    end
    ref_mem[8] = 16'hA3C2;
    mem[8]     = 16'hA3C2;

    // Reset state.
    repeat (3) tick();
    check("reset_outputs", 32'({cfg_ready, busy, done, err, drp_den, drp_dwe, drp_daddr, drp_di,
                                mmcm_rst}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("post_reset_ready", 32'(cfg_ready), 32'd1);
    check("post_reset_busy", 32'(busy), 32'd0);

    // Single register, immediate drdy.
    start_test();
    lat = 0;
    expect_reg(7'h08, 16'hF000, 16'h0145, 1'b1);
    exp_done.push_back(1'b0);
    send_req(7'h08, 16'hF000, 16'h0145, 1'b1);
    tick();
    check("t1_rst_after_accept", 32'(mmcm_rst), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    finish_batch("t1");
    check("t1_first_den_lat", rd_cycs[0] - acc_cyc, 32'd5);
    check("t1_rd_to_wr", wr_cyc - rd_cycs[0], 32'd2);
    check("t1_wr_to_release", rel_cyc - wr_cyc, 32'd2);
    check("t1_reg_value", 32'(mem[8]), 32'h0000A145);

    // Three-register batches with random contents and drdy latency.
    for (int it = 0; it < 3; it++) begin
      start_test();
      lat = $urandom_range(0, 3);
      for (int k = 0; k < 3; k++) begin
        ra[k]  = 7'($urandom);
        rm[k]  = 16'($urandom);
        rdv[k] = 16'($urandom);
        expect_reg(ra[k], rm[k], rdv[k], 1'b1);
      end
      exp_done.push_back(1'b0);
      send_req(ra[0], rm[0], rdv[0], 1'b0);
      send_req(ra[1], rm[1], rdv[1], 1'b0);
      acc2 = acc_cyc;
      check("t2_next_accept_busy", 32'(acc_busy), 32'd1);
      send_req(ra[2], rm[2], rdv[2], 1'b1);
      finish_batch("t2");
      repeat (3) tick();
      check("t2_writes_before_release", 32'(wr_cnt), 32'd3);
      check("t2_single_release", 32'(rst_falls), 32'd1);
      check("t2_single_done", 32'(done_cnt), 32'd1);
      check("t2_next_to_rd", rd_cycs[1] - acc2, 32'd1);
    end

    // DRDY boundary: response in the expiry cycle still counts as success.
    start_test();
    lat = 63;
    expect_reg(7'h12, 16'h00FF, 16'h5A5A, 1'b1);
    exp_done.push_back(1'b0);
    send_req(7'h12, 16'h00FF, 16'h5A5A, 1'b1);
    finish_batch("t3b");
    check("t3b_rd_to_wr", wr_cyc - rd_cycs[0], 32'd65);
    check("t3b_wr_to_release", rel_cyc - wr_cyc, 32'd65);

    // DRDY never returns on the second read.
    start_test();
    lat = 0;
    drop_rd = rd_idx + 1;
    expect_reg(7'h20, 16'h0F0F, 16'h1234, 1'b1);
    expect_reg(7'h21, 16'h0000, 16'hBEEF, 1'b0);
    exp_done.push_back(1'b1);
    send_req(7'h20, 16'h0F0F, 16'h1234, 1'b0);
    send_req(7'h21, 16'h0000, 16'hBEEF, 1'b0);
    tick();
    cfg_addr  = 7'h22;
    cfg_mask  = 16'h0;
    cfg_data  = 16'hCAFE;
    cfg_last  = 1'b1;
    cfg_valid = 1'b1;
    wait_release("t3");
    cfg_valid = 1'b0;
    check("t3_err_delay", err_rise_cyc - rd_cycs[1], 32'd65);
    check("t3_release_delay", rel_cyc - rd_cycs[1], 32'd65);
    check("t3_err_at_release", 32'(err), 32'd1);
    finish_batch("t3");
    check("t3_writes", 32'(wr_cnt), 32'd1);
    check("t3_reads", 32'(rd_cycs.size()), 32'd2);
    drop_rd = -1;

    // Locked stuck high at accept.
    start_test();
    lock_stuck = 1'b1;
    repeat (2) tick();
    expect_reg(7'h30, 16'hFF00, 16'h00C3, 1'b1);
    exp_done.push_back(1'b0);
    send_req(7'h30, 16'hFF00, 16'h00C3, 1'b1);
    repeat (10) tick();
    check("t4_no_den_while_locked", 32'(rd_cycs.size()), 32'd0);
    check("t4_hold_rst", 32'(mmcm_rst), 32'd1);
    @(posedge clk);
    #1;
    lock_stuck = 1'b0;
    fall_cyc = cyc;
    n = 0;
    while (rd_cycs.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    if (rd_cycs.size() == 0) begin
      checks++; errors++;
      $display("FAIL t4_den: got no drp_den in 50 cycles, expected one");
    end else check("t4_den_after_fall", rd_cycs[0] - fall_cyc, 32'd1);
    finish_batch("t4");

    // Reset asserted in WR_WAIT, drdy arrives afterwards.
    start_test();
    lat = 6;
    expect_reg(7'h40, 16'h0000, 16'h7777, 1'b1);
    send_req(7'h40, 16'h0000, 16'h7777, 1'b1);
    n = 0;
    while (wr_cnt == 0 && n < 100) begin
      tick();
      n++;
    end
    check("t5_write_seen", 32'(wr_cnt), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("t5_outputs_in_reset", 32'({cfg_ready, busy, done, err, drp_den, drp_dwe, drp_daddr,
                                      drp_di, mmcm_rst}), 32'd0);
    tick();
    check("t5_outputs_next_cycle", 32'({cfg_ready, busy, done, err, drp_den, drp_dwe, mmcm_rst}),
          32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("t5_ready_after_reset", 32'(cfg_ready), 32'd1);
    repeat (8) tick();
    check("t5_idle_after_late_drdy", 32'({busy, done_cnt[0], err, mmcm_rst}), 32'd0);
    check("t5_no_more_den", 32'(rd_cycs.size() + wr_cnt), 32'd2);
    lat = 0;

`ifdef LOCK_TIMEOUT_EN
    // Lock never arrives: timeout sets err and still completes.
    start_test();
    expect_reg(7'h50, 16'hFFFF, 16'h0, 1'b1);
    exp_done.push_back(1'b1);
    send_req(7'h50, 16'hFFFF, 16'h0, 1'b1);
    wait_release("t6");
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      tick();
      n++;
    end
    check("t6_done_seen", 32'(done_cnt), 32'd1);
    check("t6_done_delay", done_cyc - rel_cyc, 32'd100);
`endif

    repeat (4) tick();
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("done_queue_drained", 32'(exp_done.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish by 500000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mmcm_drp_ctrl.md
Name: mmcm_drp_ctrl

Overview:
- DRP master that reprograms the MMCME4_ADV counters at run time through the primitive's DRP port. The MMCM wrapper currently ties that port off.
- Accepts register read-modify-write requests and holds the MMCM in reset across a batch of writes.
- Releases reset after the batch and waits for lock before reporting completion.
- Sits in the CRG next to the MMCM wrapper, clocked by the free-running input clock that also drives DCLK.

Parameters:
- RST_HOLD, 4: minimum cycles mmcm_rst stays high before the first DRP access.
- DRDY_TIMEOUT, 64: cycles to wait for drp_drdy after a drp_den pulse before aborting.
- LOCK_TIMEOUT, 65535: cycles to wait for mmcm_locked; used only with LOCK_TIMEOUT_EN.

Ports:
- clk_in0  input  1  free-running clock; also drives the MMCM DCLK.
- reset  input  1  synchronous, active-high reset.
- cfg_valid  input  1  request valid.
- cfg_ready  output  1  request accepted when cfg_valid && cfg_ready.
- cfg_addr  input  7  DRP register address.
- cfg_mask  input  16  1 = keep the old register bit, 0 = take the cfg_data bit.
- cfg_data  input  16  new bit values.
- cfg_last  input  1  1 = final register of the batch.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when the batch ends.
- err  output  1  sticky error flag, cleared on the next IDLE accept.
- drp_den  output  1  DRP enable pulse.
- drp_dwe  output  1  DRP write enable.
- drp_daddr  output  7  DRP address.
- drp_di  output  16  DRP write data.
- drp_do  input  16  DRP read data.
- drp_drdy  input  1  DRP ready.
- mmcm_rst  output  1  MMCM RST.
- mmcm_locked  input  1  MMCM LOCKED.

Behaviour:
- Reset:
  - All outputs are 0 while reset is high; state goes to IDLE.
  - cfg_ready is 1 from the first cycle after reset falls.
  - A reset mid-batch drops mmcm_rst immediately and abandons any DRP transaction; drp_drdy arriving afterwards is ignored.
- States: IDLE, HOLD, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, RELEASE, WAIT_LOCK.
- cfg_ready is 1 only in IDLE and NEXT. cfg_addr, cfg_mask, cfg_data and cfg_last are registered on accept.
- IDLE:
  - On accept: clear err, go to HOLD.
- HOLD:
  - mmcm_rst = 1.
  - Hold counter counts RST_HOLD cycles.
  - Leave only when the count has expired and mmcm_locked == 0, then go to RD_REQ.
- RD_REQ:
  - One cycle with drp_den = 1, drp_dwe = 0, drp_daddr = stored address.
  - Go to RD_WAIT.
- RD_WAIT:
  - On drp_drdy, capture drp_do and go to WR_REQ.
- WR_REQ:
  - One cycle with drp_den = 1, drp_dwe = 1.
  - drp_di = (captured_do & mask) | (data & ~mask).
  - Go to WR_WAIT.
- WR_WAIT:
  - On drp_drdy: if stored last = 1, go to RELEASE; otherwise go to NEXT.
- DRP outputs outside RD_REQ/WR_REQ:
  - drp_den and drp_dwe are 0 in every other state.
  - drp_daddr and drp_di hold their last value.
- NEXT:
  - mmcm_rst stays 1; wait for cfg_valid.
  - On accept, go directly to RD_REQ; HOLD is not re-entered.
- RELEASE:
  - Drive mmcm_rst = 0 for one cycle, then go to WAIT_LOCK.
- WAIT_LOCK:
  - On mmcm_locked == 1, pulse done for one cycle and go to IDLE.
- DRDY timeout:
  - The cycle counter restarts on each den pulse.
  - If DRDY_TIMEOUT cycles pass in RD_WAIT or WR_WAIT without drp_drdy: set err, skip any remaining registers, go to RELEASE.
  - In that case done still pulses after lock.
- drp_drdy in any state other than RD_WAIT/WR_WAIT is ignored.
- drp_drdy arriving in the same cycle as the timeout expiry counts as success.
- Throughput:
  - With zero-latency drdy (drdy in the cycle after den), one register takes 4 cycles: RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
  - Accept-to-first-den latency is RST_HOLD + 1 cycles, assuming locked is already low.

Optional Feature:
- Macro: LOCK_TIMEOUT_EN.
- Defined:
  - WAIT_LOCK counts cycles.
  - If LOCK_TIMEOUT cycles pass without mmcm_locked: set err, pulse done, go to IDLE.
  - Lock arriving in the expiry cycle counts as success.
- Undefined:
  - WAIT_LOCK waits indefinitely.
  - err is set only by a DRDY timeout.

Test Plan:
- Single register, immediate drdy:
  - Stimulus: addr=0x08, mask=0xF000, data=0x0145; model register holds 0xA3C2.
  - Response: read at 0x08, then write drp_di=0xA145; mmcm_rst high from accept+1 until RELEASE; done pulses 1 cycle after locked rises; err=0.
- Three-register batch, cfg_last only on the third:
  - Response: exactly one HOLD; mmcm_rst continuously high across all three writes; cfg_ready high in NEXT; a single done pulse.
- DRDY never returns on the second register's read:
  - Response: err=1 after exactly 64 cycles; no write issued for that register; third register never accepted; mmcm_rst drops; done pulses after lock.
- Locked stuck high at accept:
  - Response: stays in HOLD past RST_HOLD until locked falls; first drp_den follows the fall by 1 cycle.
- Reset asserted in WR_WAIT:
  - Response: next cycle all outputs are 0; a late drp_drdy is ignored; cfg_ready is 1 after reset falls.
- LOCK_TIMEOUT_EN defined, LOCK_TIMEOUT=100, locked held low:
  - Response: err=1 and done pulses 100 cycles after RELEASE.
